// File: rtl/q_seq_mult_if.sv
// rtl/q_seq_mult_if.sv - start/busy/done handshake and operand/result bundle for q_seq_mult
interface q_seq_mult_if #(
    parameter int WIDTH = 16
);
    logic             clr;
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             ovf;

    modport master (
        output clr, start, a_in, b_in,
        input  busy, done, result, ovf
    );

    modport slave (
        input  clr, start, a_in, b_in,
        output busy, done, result, ovf
    );
endinterface

// File: rtl/q_seq_mult.sv
// rtl/q_seq_mult.sv - sequential shift-add unsigned fixed-point multiplier with saturation
module q_seq_mult #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8
) (
    input  logic        clk,
    input  logic        rst,
    q_seq_mult_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             state, state_nxt;
    logic [2*WIDTH-1:0] acc, a_sh, acc_step;
    logic [WIDTH-1:0]   b_sh;
    logic [CW-1:0]      cnt;
    logic               last_step;
    logic [WIDTH-1:0]   sat_res;
    logic               sat_ovf;
    logic [WIDTH-1:0]   result_q;
    logic               ovf_q;

    assign acc_step  = b_sh[0] ? (acc + a_sh) : acc;
    assign last_step = (cnt == CW'(WIDTH - 1));

    // Saturate when any integer bit above the output format is set.
    assign sat_ovf = |acc_step[2*WIDTH-1:WIDTH+FRAC];
    assign sat_res = sat_ovf ? {WIDTH{1'b1}} : acc_step[WIDTH+FRAC-1:FRAC];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (bus.clr) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (bus.start) state_nxt = S_RUN;
                S_RUN:   if (last_step) state_nxt = S_DONE;
                S_DONE:  state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc      <= '0;
            a_sh     <= '0;
            b_sh     <= '0;
            cnt      <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
        end else if (bus.clr) begin
            result_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        acc  <= '0;
                        a_sh <= {{WIDTH{1'b0}}, bus.a_in};
                        b_sh <= bus.b_in;
                        cnt  <= '0;
                    end
                end
                S_RUN: begin
                    acc  <= acc_step;
                    a_sh <= a_sh << 1;
                    b_sh <= b_sh >> 1;
                    cnt  <= cnt + CW'(1);
                    // Result is captured on the final step so it is stable while done is high.
                    if (last_step) begin
                        result_q <= sat_res;
                        ovf_q    <= sat_ovf;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy   = (state != S_IDLE);
    assign bus.done   = (state == S_DONE);
    assign bus.result = result_q;
    assign bus.ovf    = ovf_q;
endmodule
